par2ser_tx: RTL and testbench

PAR2SER_TX -- requirements
Module: par2ser_tx

---
 rtl/ser_pkg.sv | 15 +
 rtl/par2ser_tx.sv | 96 +++++++++
 tb/tb_par2ser_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serializer / deserializer pair.
// Holds the two-state FSM encoding and the default serial word length,
// so transmitter and receiver agree on both.
package ser_pkg;

  // Default number of bits per serial word.
  localparam int SER_DEF_BITLEN = 8;

  // Transmitter states: idle (waiting for a word) and shifting a word out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/par2ser_tx.sv
// par2ser_tx: parallel-to-serial transmitter, LSB first.
//
// A word is accepted on a Valid/Ready handshake and shifted out one bit per
// cycle starting the cycle after acceptance. Ready is re-asserted during the
// last bit so a following word continues with no gap.
//
// Ports:
//   Clk          in   sole clock, rising edge
//   Rst          in   synchronous active-high reset
//   ParDataIn    in   [BitLen] word to transmit
//   ParDataValid in   ParDataIn is offered
//   ParDataReady out  word accepted at this edge if Valid
//   SerDataOut   out  serial bit (shift register bit 0)
//   SerDataEn    out  SerDataOut is a real bit this cycle
//   TxBusy       out  a word is being shifted out
//   TxDone       out  pulse on the last bit of a word
module par2ser_tx
  import ser_pkg::*;
#(
  parameter int BitLen = SER_DEF_BITLEN
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BitLen-1:0] ParDataIn,
  input  logic              ParDataValid,
  output logic              ParDataReady,
  output logic              SerDataOut,
  output logic              SerDataEn,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam int              CntW    = $clog2(BitLen);
  localparam logic [CntW-1:0] LastCnt = CntW'(BitLen - 1);

  ser_state_e        state_q, state_d;
  logic [BitLen-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_bit;
  logic              xfer;

  // Last bit of the current word is on the line.
  assign last_bit = (state_q == SHIFT) && (cnt_q == LastCnt);
  assign xfer     = ParDataValid && ParDataReady;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = SHIFT;
      SHIFT:   if (last_bit && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Ready depends only on state/count, never on Valid.
  always_comb begin
    ParDataReady = (state_q == IDLE) || last_bit;
    SerDataEn    = (state_q == SHIFT);
    TxBusy       = (state_q == SHIFT);
    SerDataOut   = (state_q == SHIFT) && shreg_q[0];
    TxDone       = last_bit;
  end

  // Shift register and bit counter. A transfer always wins over shifting,
  // which is what makes back-to-back words seamless. After the last bit
  // without a new word the register simply holds; outputs are gated in IDLE.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      shreg_d = ParDataIn;
      cnt_d   = '0;
    end else if ((state_q == SHIFT) && !last_bit) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_par2ser_tx.sv
// Bench for par2ser_tx: an 8-bit and a 4-bit instance, checked every cycle
// against a word/bit-index model, plus literal stream expectations.
module tb_par2ser_tx;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] d8  = '0;
  logic       v8  = 1'b0;
  logic [3:0] d4  = '0;
  logic       v4  = 1'b0;

  logic rdy8, out8, en8, busy8, done8;
  logic rdy4, out4, en4, busy4, done4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  par2ser_tx #(.BitLen(8)) u_tx8 (
    .Clk(Clk), .Rst(Rst), .ParDataIn(d8), .ParDataValid(v8),
    .ParDataReady(rdy8), .SerDataOut(out8), .SerDataEn(en8),
    .TxBusy(busy8), .TxDone(done8)
  );

  par2ser_tx #(.BitLen(4)) u_tx4 (
    .Clk(Clk), .Rst(Rst), .ParDataIn(d4), .ParDataValid(v4),
    .ParDataReady(rdy4), .SerDataOut(out4), .SerDataEn(en4),
    .TxBusy(busy4), .TxDone(done4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pos = index of the bit on the line this cycle, -1 when idle.
  int         pos8 = -1, pos4 = -1;
  logic [7:0] w8 = '0;
  logic [3:0] w4 = '0;
  logic       cmp_en = 1'b0;

  function automatic logic mrdy(input int p, input int bl);
    return (p < 0) || (p == bl - 1);
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      pos8 <= -1;
      pos4 <= -1;
      cmp_en <= 1'b1;
    end else begin
      if (v8 && mrdy(pos8, 8)) begin w8 <= d8; pos8 <= 0; end
      else if (pos8 >= 0)      pos8 <= (pos8 == 7) ? -1 : pos8 + 1;
      if (v4 && mrdy(pos4, 4)) begin w4 <= d4; pos4 <= 0; end
      else if (pos4 >= 0)      pos4 <= (pos4 == 3) ? -1 : pos4 + 1;
    end
  end

  // Captured stream (either instance) and a receiver that shifts into its MSB.
  logic       q_bit[$];
  logic       q_done[$];
  logic       q_rdy[$];
  logic [7:0] rx_sr = '0;
  int         rx_n  = 0;
  logic [7:0] rx_words[$];

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("rdy8",  rdy8,  mrdy(pos8, 8));
      chk("en8",   en8,   pos8 >= 0);
      chk("busy8", busy8, pos8 >= 0);
      chk("done8", done8, pos8 == 7);
      chk("out8",  out8,  (pos8 >= 0) ? w8[pos8[2:0]] : 1'b0);
      chk("rdy4",  rdy4,  mrdy(pos4, 4));
      chk("en4",   en4,   pos4 >= 0);
      chk("busy4", busy4, pos4 >= 0);
      chk("done4", done4, pos4 == 3);
      chk("out4",  out4,  (pos4 >= 0) ? w4[pos4[1:0]] : 1'b0);
    end
    if (en8) begin
      q_bit.push_back(out8); q_done.push_back(done8); q_rdy.push_back(rdy8);
      rx_sr = {out8, rx_sr[7:1]};
      rx_n++;
      if (rx_n == 8) begin rx_words.push_back(rx_sr); rx_n = 0; end
    end
    if (en4) begin
      q_bit.push_back(out4); q_done.push_back(done4); q_rdy.push_back(rdy4);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    q_bit.delete(); q_done.delete(); q_rdy.delete();
  endtask

  // Hold the word offered until the model says it is taken; returns edges waited.
  task automatic send8(input logic [7:0] d, output int waits);
    int n;
    logic acc;
    n = 0;
    d8 = d; v8 = 1'b1;
    do begin
      acc = mrdy(pos8, 8);
      @(posedge Clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send8_timeout", 32'd0, 32'd1);
    waits = n;
  endtask

  // bits/done/rdy: bit i is the expectation for the i-th enabled cycle.
  task automatic chk_stream(input string nm, input int n, input logic [31:0] bits,
                            input logic [31:0] dn, input logic [31:0] rd);
    chk({nm, "_len"}, q_bit.size(), n);
    for (int i = 0; i < n && i < q_bit.size(); i++) begin
      chk($sformatf("%s_bit%0d", nm, i), q_bit[i], bits[i]);
      chk($sformatf("%s_done%0d", nm, i), q_done[i], dn[i]);
      chk($sformatf("%s_rdy%0d", nm, i), q_rdy[i], rd[i]);
    end
  endtask

  initial begin
    int w;
    // Reset then single word A5
    Rst = 1'b1;
    tick(2);
    @(negedge Clk);
    chk("rst_rdy", rdy8, 1'b1);
    chk("rst_en",  en8,  1'b0);
    chk("rst_out", out8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    tick(1);
    Rst = 1'b0;
    clr();
    send8(8'hA5, w); v8 = 1'b0;
    tick(10);
    chk_stream("a5", 8, 32'h000000A5, 32'h80, 32'h80);
    chk("a5_idle_rdy", rdy8, 1'b1);

    // Back-to-back 3C, C3 with Valid held
    clr();
    send8(8'h3C, w);
    send8(8'hC3, w);
    v8 = 1'b0;
    chk("b2b_wait", w, 8);
    tick(10);
    chk_stream("b2b", 16, 32'h0000C33C, 32'h8080, 32'h8080);

    // Valid during busy: FF offered at bit 3 of 00
    clr();
    send8(8'h00, w); v8 = 1'b0;
    tick(3);
    send8(8'hFF, w); v8 = 1'b0;
    chk("busy_wait", w, 5);
    tick(10);
    chk_stream("busy", 16, 32'h0000FF00, 32'h8080, 32'h8080);

    // Reset during bit 4 of FF
    clr();
    send8(8'hFF, w); v8 = 1'b0;
    tick(4);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    @(negedge Clk);
    chk("mid_en",  en8,  1'b0);
    chk("mid_out", out8, 1'b0);
    chk("mid_rdy", rdy8, 1'b1);
    tick(10);
    chk_stream("mid", 5, 32'h1F, 32'h0, 32'h0);

    // Loopback into an MSB-first-shifting receiver
    clr();
    rx_n = 0; rx_words.delete();
    send8(8'h01, w); v8 = 1'b0; tick(9);
    send8(8'h80, w); v8 = 1'b0; tick(9);
    send8(8'h5A, w); v8 = 1'b0; tick(9);
    chk("rx_cnt", rx_words.size(), 3);
    if (rx_words.size() == 3) begin
      chk("rx0", rx_words[0], 8'h01);
      chk("rx1", rx_words[1], 8'h80);
      chk("rx2", rx_words[2], 8'h5A);
    end

    // 4-bit instance: 9 -> 1,0,0,1
    clr();
    d4 = 4'h9; v4 = 1'b1;
    tick(1);
    v4 = 1'b0; d4 = 4'h0;
    tick(6);
    chk_stream("bl4", 4, 32'h9, 32'h8, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
